// File: rtl/lte_frame_timing_gen.sv
// LTE radio-frame timebase flywheel: sample/subframe/SFN counters locked to the protected frame head.
// Optional SFN preload ports and logic are compiled in when SFN_LOAD_EN is defined.
module lte_frame_timing_gen #(
  parameter int SUBFRM_LEN  = 245760,
  parameter int SFN_MAX     = 1023,
  parameter int LOSS_THRESH = 3
) (
  input  logic        clk,
  input  logic        asy_rst_n,
  input  logic        i_int_hd,
`ifdef SFN_LOAD_EN
  input  logic        i_sfn_load,
  input  logic [9:0]  i_sfn_val,
`endif
  output logic        o_frm_hd,
  output logic        o_sfrm_hd,
  output logic [3:0]  o_sfrm_no,
  output logic [17:0] o_smp_cnt,
  output logic [9:0]  o_sfn,
  output logic        o_lock,
  output logic        o_hd_lost,
  output logic [7:0]  o_realign_cnt
);

  localparam int MISS_W = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);
  localparam logic [17:0]       SMP_LAST  = 18'(SUBFRM_LEN - 1);
  localparam logic [9:0]        SFN_TOP   = 10'(SFN_MAX);
  localparam logic [MISS_W-1:0] MISS_TOP  = MISS_W'(LOSS_THRESH);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [MISS_W-1:0] miss, miss_nxt;
  logic [17:0]       smp_nxt;
  logic [3:0]        sfrm_nxt;
  logic [9:0]        sfn_nxt, sfn_inc, sfn_frame, sfn_first;
  logic [7:0]        realign_nxt;
  logic              frm_nxt, sfhd_nxt, bnd;

  assign bnd     = (o_smp_cnt == SMP_LAST) && (o_sfrm_no == 4'd9);
  assign sfn_inc = (o_sfn == SFN_TOP) ? 10'd0 : o_sfn + 10'd1;

`ifdef SFN_LOAD_EN
  // A pending load is consumed by whichever update raises o_frm_hd; a new arm wins over the clear.
  logic       ld_pend;
  logic [9:0] ld_val;

  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      ld_pend <= 1'b0;
      ld_val  <= '0;
    end else if (i_sfn_load) begin
      ld_pend <= 1'b1;
      ld_val  <= i_sfn_val;
    end else if (frm_nxt) begin
      ld_pend <= 1'b0;
    end
  end

  assign sfn_frame = ld_pend ? ld_val : sfn_inc;
  assign sfn_first = ld_pend ? ld_val : 10'd0;
`else
  assign sfn_frame = sfn_inc;
  assign sfn_first = 10'd0;
`endif

  always_comb begin
    state_nxt   = state;
    miss_nxt    = miss;
    smp_nxt     = o_smp_cnt;
    sfrm_nxt    = o_sfrm_no;
    sfn_nxt     = o_sfn;
    realign_nxt = o_realign_cnt;
    frm_nxt     = 1'b0;
    sfhd_nxt    = 1'b0;
    case (state)
      HUNT: begin
        if (i_int_hd) begin
          state_nxt = LOCK;
          miss_nxt  = '0;
          smp_nxt   = '0;
          sfrm_nxt  = '0;
          sfn_nxt   = sfn_first;
          frm_nxt   = 1'b1;
          sfhd_nxt  = 1'b1;
        end
      end
      default: begin
        if (i_int_hd) begin
          // Aligned or not, a head restarts the frame; off-boundary heads also count a realign.
          state_nxt = LOCK;
          miss_nxt  = '0;
          smp_nxt   = '0;
          sfrm_nxt  = '0;
          sfn_nxt   = sfn_frame;
          frm_nxt   = 1'b1;
          sfhd_nxt  = 1'b1;
          if (!bnd && o_realign_cnt != 8'hFF)
            realign_nxt = o_realign_cnt + 8'd1;
        end else begin
          if (o_smp_cnt == SMP_LAST) begin
            smp_nxt  = '0;
            sfhd_nxt = 1'b1;
            if (o_sfrm_no == 4'd9) begin
              sfrm_nxt = '0;
              sfn_nxt  = sfn_frame;
              frm_nxt  = 1'b1;
            end else begin
              sfrm_nxt = o_sfrm_no + 4'd1;
            end
          end else begin
            smp_nxt = o_smp_cnt + 18'd1;
          end
          if (bnd) begin
            if (miss >= MISS_LAST) begin
              miss_nxt  = MISS_TOP;
              state_nxt = HOLD;
            end else begin
              miss_nxt = miss + MISS_W'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      state <= HUNT;
      miss  <= '0;
    end else begin
      state <= state_nxt;
      miss  <= miss_nxt;
    end
  end

  // Status flags follow the state register by one cycle.
  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      o_frm_hd      <= 1'b0;
      o_sfrm_hd     <= 1'b0;
      o_sfrm_no     <= '0;
      o_smp_cnt     <= '0;
      o_sfn         <= '0;
      o_lock        <= 1'b0;
      o_hd_lost     <= 1'b0;
      o_realign_cnt <= '0;
    end else begin
      o_frm_hd      <= frm_nxt;
      o_sfrm_hd     <= sfhd_nxt;
      o_sfrm_no     <= sfrm_nxt;
      o_smp_cnt     <= smp_nxt;
      o_sfn         <= sfn_nxt;
      o_lock        <= (state == LOCK);
      o_hd_lost     <= (state == HOLD);
      o_realign_cnt <= realign_nxt;
    end
  end

endmodule
